// File: rtl/alu_pkg.sv
// Opcode constants and FSM state encoding shared by the alu_md block.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] f);
        return (f == OP_MULU) || (f == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_if.sv
// Request/result bundle between a requester (master) and alu_md (slave).
interface alu_md_if #(parameter int WIDTH = 32) ();

    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       f_in;
    logic             valid_out;
    logic [WIDTH-1:0] y_out;
    logic [WIDTH-1:0] hi_out;
    logic             zero_out;
    logic             c_out;
    logic             ovf_out;

    modport master (
        output valid_in, a_in, b_in, f_in,
        input  ready_out, valid_out, y_out, hi_out, zero_out, c_out, ovf_out
    );

    modport slave (
        input  valid_in, a_in, b_in, f_in,
        output ready_out, valid_out, y_out, hi_out, zero_out, c_out, ovf_out
    );

endinterface

// File: rtl/md_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_q;
    logic             div_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opb_q;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [WIDTH:0]   sum_w, rem_w;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        sum_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        rem_w = {hi_q, lo_q[WIDTH-1]};
        if (div_q) begin
            // remainder < divisor afterwards, so a WIDTH-bit subtract is exact
            if (rem_w >= {1'b0, opb_q}) begin
                hi_d = rem_w[WIDTH-1:0] - opb_q;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = rem_w[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_d, lo_d} = {sum_w, lo_q[WIDTH-1:1]};
        end
    end

    // Final step's value is presented alongside done_o so the caller can latch it.
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign lo_o   = lo_d;
    assign hi_o   = hi_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            div_q  <= div_i;
            cnt_q  <= CW'(WIDTH);
            hi_q   <= '0;
            lo_q   <= a_i;
            opb_q  <= b_i;
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_md.sv
// ALU with single-cycle logic/arith ops and an iterative multiply/divide unit.
// state | meaning
// IDLE  | ready for a request
// BUSY  | md_iter running WIDTH steps
// DONE  | results valid, valid_out pulse
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk_in,
    input logic     rst_in,
    alu_md_if.slave bus
);

    state_e           state_q;
    logic [WIDTH-1:0] y_q, hi_q;
    logic             zero_q, c_q, ovf_q;

    logic             accept, start_iter;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi;

    logic [WIDTH:0]   add_w, sub_w;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c, alu_ovf;

    assign accept     = (state_q == ST_IDLE) && bus.valid_in;
    assign start_iter = accept && is_iter_op(bus.f_in);

    md_iter #(.WIDTH(WIDTH)) u_md_iter (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .start_i (start_iter),
        .div_i   (bus.f_in == OP_DIVU),
        .a_i     (bus.a_in),
        .b_i     (bus.b_in),
        .done_o  (iter_done),
        .lo_o    (iter_lo),
        .hi_o    (iter_hi)
    );

    always_comb begin
        add_w   = {1'b0, bus.a_in} + {1'b0, bus.b_in};
        sub_w   = {1'b0, bus.a_in} + {1'b0, ~bus.b_in} + {{WIDTH{1'b0}}, 1'b1};
        add_ovf = (bus.a_in[WIDTH-1] == bus.b_in[WIDTH-1]) && (add_w[WIDTH-1] != bus.a_in[WIDTH-1]);
        sub_ovf = (bus.a_in[WIDTH-1] != bus.b_in[WIDTH-1]) && (sub_w[WIDTH-1] != bus.a_in[WIDTH-1]);
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_ovf = 1'b0;
        case (bus.f_in)
            OP_AND: alu_y = bus.a_in & bus.b_in;
            OP_OR:  alu_y = bus.a_in | bus.b_in;
            OP_ADD: begin
                alu_y   = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_ovf = add_ovf;
            end
            OP_SUB: begin
                alu_y   = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_ovf = sub_ovf;
            end
            // Sign of the difference corrected by overflow gives the true signed compare.
            OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ovf};
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_iter_op(bus.f_in)) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_DONE;
                            y_q     <= alu_y;
                            hi_q    <= '0;
                            zero_q  <= (alu_y == '0);
                            c_q     <= alu_c;
                            ovf_q   <= alu_ovf;
                        end
                    end
                end
                ST_BUSY: begin
                    if (iter_done) begin
                        state_q <= ST_DONE;
                        y_q     <= iter_lo;
                        hi_q    <= iter_hi;
                        zero_q  <= (iter_lo == '0);
                        c_q     <= 1'b0;
                        ovf_q   <= 1'b0;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_out = (state_q == ST_IDLE);
    assign bus.valid_out = (state_q == ST_DONE);
    assign bus.y_out     = y_q;
    assign bus.hi_out    = hi_q;
    assign bus.zero_out  = zero_q;
    assign bus.c_out     = c_q;
    assign bus.ovf_out   = ovf_q;

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32.
module tb_alu_md;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_md_if #(.WIDTH(32)) bus ();
    alu_md #(.WIDTH(32)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.ready_out, 1);
        check({tag, "_valid"}, bus.valid_out, 0);
        check({tag, "_y"},     bus.y_out,     0);
        check({tag, "_hi"},    bus.hi_out,    0);
        check({tag, "_flags"}, {bus.zero_out, bus.c_out, bus.ovf_out}, 3'b100);
    endtask

    task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_y,
                          input logic [31:0] exp_hi, input logic exp_c,
                          input logic exp_ovf, input int exp_lat);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        check({tag, "_ready"}, bus.ready_out, 1);
        bus.f_in     = f;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.a_in     = ~a;
        bus.b_in     = b ^ 32'h5A5A_5A5A;
        bus.f_in     = OP_SUB;
        lat          = 0;
        busy_ok      = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.valid_out) begin
                lat = i;
                break;
            end
            if (bus.ready_out) busy_ok = 1'b0;
        end
        check({tag, "_lat"},   lat, exp_lat);
        check({tag, "_busy"},  busy_ok, 1);
        check({tag, "_y"},     bus.y_out, exp_y);
        check({tag, "_hi"},    bus.hi_out, exp_hi);
        check({tag, "_flags"}, {bus.zero_out, bus.c_out, bus.ovf_out},
              {(exp_y == 32'd0), exp_c, exp_ovf});
        @(negedge clk);
        check({tag, "_pulse"}, bus.valid_out, 0);
        check({tag, "_hold"},  bus.y_out, exp_y);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] exp_v;
        int          accepts;
        int          seen_valid;

        bus.valid_in = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.f_in     = OP_AND;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        run_op("add_wrap",  OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0, 1, 0, 1);
        run_op("sub_ovf",   OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 1, 1);
        run_op("slt_neg",   OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 1);
        run_op("slt_pos",   OP_SLT,  32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 0, 0, 0, 1);
        run_op("and",       OP_AND,  32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 0, 0, 0, 1);
        run_op("or",        OP_OR,   32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'hFCFC_FCFC, 0, 0, 0, 1);
        run_op("add_ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 1);
        run_op("mulu_max",  OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 33);
        run_op("mulu_16",   OP_MULU, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 32'h0000_0001, 0, 0, 33);
        run_op("divu_100_7", OP_DIVU, 32'd100,      32'd7,         32'd14,        32'd2,         0, 0, 33);
        run_op("divu_by0",  OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         0, 0, 33);
        run_op("illegal",   4'b0011, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 0, 0, 0, 1);

        // Abort a multiply 10 cycles in.
        @(negedge clk);
        bus.f_in     = OP_MULU;
        bus.a_in     = 32'h0000_0003;
        bus.b_in     = 32'h0000_0005;
        bus.valid_in = 1'b1;
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        seen_valid = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.valid_out) seen_valid++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (40) begin
            @(negedge clk);
            if (bus.valid_out) seen_valid++;
        end
        check("abort_no_valid", seen_valid, 0);
        run_op("post_abort_add", OP_ADD, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1);

        // Reset wins over a simultaneous request.
        @(negedge clk);
        bus.f_in     = OP_ADD;
        bus.a_in     = 32'd7;
        bus.b_in     = 32'd8;
        bus.valid_in = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_vs_valid");

        // valid_in held high with fresh operands every cycle.
        accepts    = 0;
        seen_valid = 0;
        bus.f_in   = OP_ADD;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.valid_out) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("b2b_y", bus.y_out, exp_v);
                seen_valid++;
            end
            bus.a_in     = 32'(k + 1);
            bus.b_in     = 32'((k + 1) * 256);
            bus.valid_in = 1'b1;
            if (bus.ready_out) begin
                exp_q.push_back(32'(k + 1) + 32'((k + 1) * 256));
                accepts++;
            end
        end
        @(posedge clk);
        #1 bus.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.valid_out) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check("b2b_y", bus.y_out, exp_v);
                seen_valid++;
            end
        end
        check("b2b_accepts", accepts, 6);
        check("b2b_results", seen_valid, 6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; legal values 8..64, even.
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  operation request.
REQ-005 ready_out  output  1  block accepts a request this cycle.
REQ-006 a_in  input  WIDTH  operand A.
REQ-007 b_in  input  WIDTH  operand B.
REQ-008 f_in  input  4  opcode (see REQ-012).
REQ-009 valid_out  output  1  one-cycle pulse: result registers updated.
REQ-010 y_out  output  WIDTH  result low word (quotient for DIVU).
REQ-011 hi_out, zero_out, c_out, ovf_out  output  WIDTH/1/1/1  high word (remainder for DIVU); y_out==0; carry-out; signed overflow.

Function
REQ-012 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A+~B+1), 0111 SLT (signed, y=1/0), 1000 MULU (unsigned 2*WIDTH product {hi_out,y_out}), 1001 DIVU (unsigned); all other codes are illegal.
REQ-013 Request accepted on an edge where valid_in && ready_out; operands and opcode captured at that edge; later changes to inputs are ignored.
REQ-014 FSM states IDLE, BUSY, DONE; ready_out = (state==IDLE).
REQ-015 IDLE: on accept of AND/OR/ADD/SUB/SLT or an illegal opcode -> DONE; on accept of MULU/DIVU -> BUSY; no accept -> stay IDLE.
REQ-016 BUSY: iterative unit runs exactly WIDTH cycles, one bit per cycle (shift-add multiply, restoring divide), then -> DONE.
REQ-017 DONE: valid_out=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-018 Latency from accepting edge to valid_out high: 1 cycle for single-cycle ops, WIDTH+1 cycles for MULU/DIVU; next request accepted no earlier than 2 cycles after the previous one.
REQ-019 Result outputs update only on the edge entering DONE and hold until the next result.
REQ-020 ADD/SUB: c_out = carry out of bit WIDTH-1; ovf_out = signed overflow; hi_out=0.
REQ-021 AND/OR/SLT/MULU/DIVU: c_out=0, ovf_out=0; for AND/OR/SLT, hi_out=0.
REQ-022 SLT computes the true signed result: y = (A-B sign) XOR ovf.
REQ-023 DIVU with b==0: y_out = all ones, hi_out = A, still WIDTH+1 latency.
REQ-024 Illegal opcode: y_out=0, hi_out=0, zero_out=1, flags 0, 1-cycle latency.
REQ-025 zero_out reflects y_out only (hi_out ignored).

Reset
REQ-026 rst_in high at an edge: state=IDLE, valid_out=0, y_out=0, hi_out=0, zero_out=1, c_out=0, ovf_out=0, ready_out=1 after that edge.
REQ-027 Reset in BUSY or DONE aborts the operation; no valid_out for it; reset wins over a simultaneous valid_in.

Structure
REQ-028 Shared package alu_pkg holds opcode constants and the FSM state encoding.
REQ-029 One sub-module md_iter (iterative multiply/divide datapath with start, op, done) instantiated once; single-cycle ops stay in alu_md.

Verification (WIDTH=32)
REQ-030 ADD 0xFFFFFFFF+0x00000001 -> y=0, zero=1, c=1, ovf=0, valid_out 1 cycle after accept.
REQ-031 SUB 0x80000000-0x00000001 -> y=0x7FFFFFFF, ovf=1; SLT 0x80000000,0x00000001 -> y=1.
REQ-032 MULU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, y=0x00000001, valid_out exactly 33 cycles after accept, ready_out low throughout.
REQ-033 DIVU 100/7 -> y=14, hi=2; DIVU 5/0 -> y=0xFFFFFFFF, hi=5.
REQ-034 Reset asserted 10 cycles into MULU -> no valid_out, ready_out=1 next cycle, outputs at REQ-026 values; new ADD 2+3 then yields y=5.
REQ-035 valid_in held high continuously with back-to-back ADDs -> accepts every 2nd cycle, each valid_out paired with its own operands.
